// File: rtl/counter_pkg.sv
// Shared constants for the up/down event counter family.
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;
    localparam int CNT_W    = 10;

endpackage

// File: rtl/edge_sync.sv
// Synchronises an asynchronous strobe into clk and flags each rising edge
// with a one-cycle pulse driven only from flops.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_async};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Both operands are flops, so the edge pulse has no path from d_async.
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/updown_counter_sync.sv
// Fully synchronous up/down event counter with wrap or saturate mode,
// clear/load and registered boundary and overflow/underflow flags.
module updown_counter_sync
    import counter_pkg::*;
#(
    parameter int WIDTH       = CNT_W,
    parameter int SATURATE    = CNT_WRAP,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH:0]   ONE_X   = {{WIDTH{1'b0}}, 1'b1};

    logic             up, dn;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH:0]   sum, diff;

    edge_sync #(.STAGES(SYNC_STAGES)) u_inc_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (inc),
        .rise    (up)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_dec_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (dec),
        .rise    (dn)
    );

    // The extra top bit of sum/diff is the carry out of max / borrow out of zero.
    assign sum  = {1'b0, cnt_q} + ONE_X;
    assign diff = {1'b0, cnt_q} - ONE_X;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_value;
        end else if (up && !dn) begin
            ovf_d = sum[WIDTH];
            if (sum[WIDTH] && (SATURATE != CNT_WRAP)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = sum[WIDTH-1:0];
            end
        end else if (dn && !up) begin
            unf_d = diff[WIDTH];
            if (diff[WIDTH] && (SATURATE != CNT_WRAP)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = diff[WIDTH-1:0];
            end
        end
        at_max_d = (cnt_d == MAX_VAL);
        at_min_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign counter = cnt_q;
    assign at_max  = at_max_q;
    assign at_min  = at_min_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_updown_counter_sync.sv
// Directed bench driving a wrap-mode and a saturate-mode counter side by side
// from the same stimulus; every expected value is written out by hand.
module tb_updown_counter_sync;

    localparam int W = 10;

    typedef enum logic [2:0] {OP_INC, OP_DEC, OP_BOTH, OP_LOAD, OP_CLR, OP_CLRLOAD} opKind_e;

    typedef struct {
        opKind_e op;
        int      value;
        int      wCnt;
        int      sCnt;
        int      wOvf;
        int      wUnf;
        int      sOvf;
        int      sUnf;
    } vector_t;

    logic         clk;
    logic         rst;
    logic         inc;
    logic         dec;
    logic         clr;
    logic         load;
    logic [W-1:0] loadValue;

    logic [W-1:0] cntW, cntS;
    logic         atMaxW, atMinW, ovfW, unfW;
    logic         atMaxS, atMinS, ovfS, unfS;

    int checkCount = 0;
    int failCount  = 0;
    int seenOvfW, seenUnfW, seenOvfS, seenUnfS;

    vector_t vecs[14];

    updown_counter_sync #(.WIDTH(W), .SATURATE(0), .SYNC_STAGES(2)) dutWrap (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .dec        (dec),
        .clr        (clr),
        .load       (load),
        .load_value (loadValue),
        .counter    (cntW),
        .at_max     (atMaxW),
        .at_min     (atMinW),
        .ovf        (ovfW),
        .unf        (unfW)
    );

    updown_counter_sync #(.WIDTH(W), .SATURATE(1), .SYNC_STAGES(2)) dutSat (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .dec        (dec),
        .clr        (clr),
        .load       (load),
        .load_value (loadValue),
        .counter    (cntS),
        .at_max     (atMaxS),
        .at_min     (atMinS),
        .ovf        (ovfS),
        .unf        (unfS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkDuts(input string name, input int wExp, input int sExp);
        checkOutput({name, " wrap count"}, int'(cntW), wExp);
        checkOutput({name, " wrap at_max"}, int'(atMaxW), int'(wExp == 1023));
        checkOutput({name, " wrap at_min"}, int'(atMinW), int'(wExp == 0));
        checkOutput({name, " sat count"}, int'(cntS), sExp);
        checkOutput({name, " sat at_max"}, int'(atMaxS), int'(sExp == 1023));
        checkOutput({name, " sat at_min"}, int'(atMinS), int'(sExp == 0));
    endtask

    // Inputs change just after a falling edge; outputs are sampled there too.
    task automatic step();
        @(negedge clk);
        seenOvfW += int'(ovfW);
        seenUnfW += int'(unfW);
        seenOvfS += int'(ovfS);
        seenUnfS += int'(unfS);
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        int holdCycles;
        string name;
        seenOvfW = 0;
        seenUnfW = 0;
        seenOvfS = 0;
        seenUnfS = 0;
        holdCycles = 1;
        case (v.op)
            OP_INC:     begin inc = 1'b1; holdCycles = 4; end
            OP_DEC:     begin dec = 1'b1; holdCycles = 4; end
            OP_BOTH:    begin inc = 1'b1; dec = 1'b1; holdCycles = 4; end
            OP_LOAD:    begin load = 1'b1; loadValue = W'(v.value); end
            OP_CLR:     clr = 1'b1;
            OP_CLRLOAD: begin clr = 1'b1; load = 1'b1; loadValue = W'(v.value); end
            default:    ;
        endcase
        repeat (holdCycles) step();
        inc  = 1'b0;
        dec  = 1'b0;
        clr  = 1'b0;
        load = 1'b0;
        repeat (4) step();
        name = $sformatf("vec%0d", idx);
        checkDuts(name, v.wCnt, v.sCnt);
        checkOutput({name, " wrap ovf pulses"}, seenOvfW, v.wOvf);
        checkOutput({name, " wrap unf pulses"}, seenUnfW, v.wUnf);
        checkOutput({name, " sat ovf pulses"}, seenOvfS, v.sOvf);
        checkOutput({name, " sat unf pulses"}, seenUnfS, v.sUnf);
    endtask

    // One strobe edge with cycle-exact checks around the counter update.
    task automatic strobeEdge(input string name, input bit isInc, input int wCnt, input int sCnt,
                              input int wFlag, input int sFlag);
        if (isInc) inc = 1'b1;
        else dec = 1'b1;
        step();
        step();
        checkOutput({name, " wrap flag early"}, int'(isInc ? ovfW : unfW), 0);
        checkOutput({name, " sat flag early"}, int'(isInc ? ovfS : unfS), 0);
        step();
        checkDuts(name, wCnt, sCnt);
        checkOutput({name, " wrap flag"}, int'(isInc ? ovfW : unfW), wFlag);
        checkOutput({name, " sat flag"}, int'(isInc ? ovfS : unfS), sFlag);
        step();
        checkOutput({name, " wrap flag after"}, int'(isInc ? ovfW : unfW), 0);
        checkOutput({name, " sat flag after"}, int'(isInc ? ovfS : unfS), 0);
        inc = 1'b0;
        dec = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        vecs[0]  = '{OP_INC,     0,    2,    2,    0, 0, 0, 0};
        vecs[1]  = '{OP_INC,     0,    3,    3,    0, 0, 0, 0};
        vecs[2]  = '{OP_LOAD,    1022, 1022, 1022, 0, 0, 0, 0};
        vecs[3]  = '{OP_INC,     0,    1023, 1023, 0, 0, 0, 0};
        vecs[4]  = '{OP_INC,     0,    0,    1023, 1, 0, 1, 0};
        vecs[5]  = '{OP_DEC,     0,    1023, 1022, 0, 1, 0, 0};
        vecs[6]  = '{OP_CLR,     0,    0,    0,    0, 0, 0, 0};
        vecs[7]  = '{OP_DEC,     0,    1023, 0,    0, 1, 0, 1};
        vecs[8]  = '{OP_LOAD,    500,  500,  500,  0, 0, 0, 0};
        vecs[9]  = '{OP_BOTH,    0,    500,  500,  0, 0, 0, 0};
        vecs[10] = '{OP_CLRLOAD, 77,   0,    0,    0, 0, 0, 0};
        vecs[11] = '{OP_LOAD,    1,    1,    1,    0, 0, 0, 0};
        vecs[12] = '{OP_DEC,     0,    0,    0,    0, 0, 0, 0};
        vecs[13] = '{OP_DEC,     0,    1023, 0,    0, 1, 0, 1};

        rst       = 1'b1;
        inc       = 1'b0;
        dec       = 1'b0;
        clr       = 1'b0;
        load      = 1'b0;
        loadValue = '0;
        seenOvfW  = 0;
        seenUnfW  = 0;
        seenOvfS  = 0;
        seenUnfS  = 0;
        step();
        checkDuts("reset", 0, 0);
        checkOutput("reset wrap ovf", int'(ovfW), 0);
        checkOutput("reset wrap unf", int'(unfW), 0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] first increment latency");
        inc = 1'b1;
        step();
        checkDuts("lat edgeN", 0, 0);
        step();
        checkDuts("lat edgeN1", 0, 0);
        step();
        checkDuts("lat edgeN2", 1, 1);
        step();
        inc = 1'b0;
        repeat (4) step();

        $display("[TB] table vectors");
        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

        $display("[TB] boundary pulses");
        clr = 1'b1;
        step();
        clr = 1'b0;
        load = 1'b1;
        loadValue = 10'd1023;
        step();
        load = 1'b0;
        checkDuts("load max", 1023, 1023);
        strobeEdge("inc at max", 1'b1, 0, 1023, 1, 1);
        strobeEdge("inc again", 1'b1, 1, 1023, 0, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        checkDuts("clear", 0, 0);
        strobeEdge("dec at zero", 1'b0, 1023, 0, 1, 1);

        $display("[TB] strobe held through reset");
        rst = 1'b1;
        inc = 1'b1;
        repeat (3) step();
        checkDuts("held in reset", 0, 0);
        rst = 1'b0;
        repeat (8) step();
        checkDuts("held release", 1, 1);
        inc = 1'b0;
        repeat (4) step();
        checkDuts("held drop", 1, 1);

        $display("[TB] async reset mid-cycle");
        load = 1'b1;
        loadValue = 10'd42;
        step();
        load = 1'b0;
        checkDuts("load 42", 42, 42);
        #2;
        rst = 1'b1;
        #1;
        checkDuts("async reset", 0, 0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] load during strobe latency");
        inc = 1'b1;
        step();
        load = 1'b1;
        loadValue = 10'd200;
        step();
        load = 1'b0;
        checkDuts("load pending", 200, 200);
        step();
        checkDuts("pending matures", 201, 201);
        step();
        inc = 1'b0;
        repeat (4) step();
        checkDuts("pending settle", 201, 201);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/updown_counter_sync.md
# updown_counter_sync

Parametrised, fully synchronous up/down event counter. It replaces the earlier ripple-clocked, increment-only counter. Asynchronous `inc`/`dec` strobes (buttons, external pulses) are synchronised into `clk`, rising-edge detected, and applied to a WIDTH-bit count. The count supports wrap or saturate mode, synchronous clear/load, and boundary flags. The block sits between raw board inputs and display/control logic on the Elbert V2 design.

## Interface
Parameters:
- `WIDTH`, 10: count width in bits (≥2).
- `SATURATE`, 0: 0 = wrap modulo 2^WIDTH; 1 = clamp at 0 and 2^WIDTH−1.
- `SYNC_STAGES`, 2: synchroniser depth per strobe input (≥2).

Ports:
- `clk`  in  1: single system clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `inc`  in  1: asynchronous increment strobe; each rising edge = +1.
- `dec`  in  1: asynchronous decrement strobe; each rising edge = −1.
- `clr`  in  1: synchronous clear, `clk`-domain.
- `load`  in  1: synchronous load, `clk`-domain.
- `load_value`  in  WIDTH: value taken when `load`=1.
- `counter`  out  WIDTH: current count, registered.
- `at_max`  out  1: `counter` == 2^WIDTH−1, registered.
- `at_min`  out  1: `counter` == 0, registered.
- `ovf`  out  1: one-cycle pulse on an increment at max (wraps or clamps).
- `unf`  out  1: one-cycle pulse on a decrement at 0 (wraps or clamps).

## Operation
- Reset (async assert, sync use): all synchroniser flops, edge-history flops, `counter`, `ovf` and `unf` go to 0. `at_min` goes to 1 and `at_max` to 0.
- Each strobe passes through a SYNC_STAGES flop chain. The chain output is compared with a one-flop delayed copy: `up` = sync & ~prev (same for `dn`).
- A strobe held high through reset release counts exactly once.
- Priority per cycle: `clr` > `load` > strobes.
  - `clr`: `counter`←0.
  - `load`: `counter`←`load_value`.
  - `ovf`/`unf` are forced 0 on `clr` and `load` cycles.
- Strobes:
  - `up` & `dn` in the same cycle: no change, no flags.
  - `up` only: +1.
  - `dn` only: −1.
  - Neither: hold.
- Wrap mode (SATURATE=0):
  - 2^WIDTH−1 + 1 → 0, with `ovf`=1.
  - 0 − 1 → 2^WIDTH−1, with `unf`=1.
- Saturate mode (SATURATE=1):
  - At max, +1 holds the count, with `ovf`=1.
  - At 0, −1 holds the count, with `unf`=1.
- `at_max`/`at_min` are registered from the next-count value, so they are always coherent with `counter` in the same cycle.
- Arithmetic is WIDTH bits unsigned, computed with a WIDTH+1 carry/borrow bit.
- Strobe edges closer together than (SYNC_STAGES+1) `clk` periods may be merged. Minimum strobe high and low time is 2 `clk` periods.
- `clr`/`load` arriving during a strobe's synchroniser latency do not drop the strobe. The pending `up`/`dn` applies on its own cycle after the clear/load.

## Timing
- Strobe latency: an `inc` rising edge first sampled at clock edge N updates `counter` at edge N+SYNC_STAGES. With SYNC_STAGES=2, the new value is visible after the 3rd edge.
- `clr`/`load` latency: 1 cycle (value visible after the next rising edge).
- `ovf`/`unf` are high for exactly the one cycle in which `counter` shows the wrapped or clamped result.
- Reset mid-operation: outputs go to reset values immediately, independent of `clk`. In-flight strobes in the synchronisers are discarded.
- No combinational path from any input to any output.

## Structure
- Shared package `counter_pkg`:
  - mode constants `CNT_WRAP`=0 and `CNT_SAT`=1;
  - default width constant `CNT_W`=10.
- Sub-module `edge_sync`:
  - parameter `STAGES`;
  - ports `clk`, `rst`, `d_async`, `rise`;
  - contains the flop chain plus the edge-history flop and registered edge detector.
- Top level: two `edge_sync` instances plus the counter/flag register block. Estimated 150–250 RTL lines total.

## Test plan
- Reset, then three isolated `inc` pulses, each 4 cycles wide with 4-cycle gaps (WIDTH=10, SATURATE=0) → `counter`=3. Each update lands exactly SYNC_STAGES edges after first sampling. `at_min` falls with the first increment.
- Wrap boundaries:
  - `load_value`=1023 with `load`, then one `inc` → `counter`=0, `ovf`=1 for one cycle, `at_max` 1→0.
  - From 0, one `dec` → 1023, with `unf`=1.
- SATURATE=1 at 1023: two `inc` → stays 1023, `ovf` pulses twice, `at_max` stays 1. At 0, `dec` → stays 0 with `unf`=1.
- `inc` and `dec` rising on the same `clk` edge (counter=500) → stays 500, no flags. Then `clr` and `load`(77) asserted together → `counter`=0.
- `inc` held high through `rst` release → exactly one increment (counter=1). Asserting `rst` mid-stream while `counter`=42 → `counter`=0 and `at_min`=1 within the same cycle, without waiting for `clk`.
- `load`(200) issued one cycle after an `inc` edge is sampled → `counter`=200, then 201 when the pending strobe matures.
